// File: rtl/abc_to_dq_if.sv
// Request/result bundle for abc_to_dq: sampled phase currents, rotor angle, d/q results.
`timescale 1ns/1ps
interface abc_to_dq_if #(
  parameter int unsigned N = 24
);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] C;
  logic [N-1:0] CosQ;
  logic [N-1:0] SinQ;
  logic         busy;
  logic         done;
  logic [N-1:0] d;
  logic [N-1:0] q;

  modport master (output start, A, B, C, CosQ, SinQ, input busy, done, d, q);
  modport slave  (input start, A, B, C, CosQ, SinQ, output busy, done, d, q);
endinterface

// File: rtl/abc_to_dq.sv
// Forward Clarke/Park transform, sign-magnitude Q12, one shared multiplier under a start/done FSM.
// Define ABC_3PH_EN to use all three phase currents (latency 9 instead of 7).
`timescale 1ns/1ps
module abc_to_dq #(
  parameter int unsigned N = 24,
  parameter int unsigned Q = 12
) (
  input logic        clk,
  input logic        rst_n,
  abc_to_dq_if.slave bus
);
  localparam int unsigned MW = N - 1;
  localparam logic [N-1:0] K3 = N'(2365);
  localparam logic [N-1:0] K1 = N'(1365);

  // Magnitude product rescaled by Q, upper bits dropped; -0 is allowed here.
  function automatic logic [N-1:0] sm_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [2*MW-1:0] prod;
    prod = {{MW{1'b0}}, x[MW-1:0]} * {{MW{1'b0}}, y[MW-1:0]};
    return {x[N-1] ^ y[N-1], MW'(prod >> Q)};
  endfunction

  function automatic logic [N-1:0] sm_add(input logic [N-1:0] x, input logic [N-1:0] y);
    logic [MW-1:0] mr;
    logic          sr;
    if (x[N-1] == y[N-1]) begin
      mr = x[MW-1:0] + y[MW-1:0];
      sr = x[N-1];
    end else if (x[MW-1:0] >= y[MW-1:0]) begin
      mr = x[MW-1:0] - y[MW-1:0];
      sr = x[N-1];
    end else begin
      mr = y[MW-1:0] - x[MW-1:0];
      sr = y[N-1];
    end
    if (mr == '0) sr = 1'b0;
    return {sr, mr};
  endfunction

  function automatic logic [N-1:0] sm_neg(input logic [N-1:0] x);
    return {~x[N-1], x[MW-1:0]};
  endfunction

  typedef enum logic [3:0] {
    S_IDLE, S_PRE,
`ifdef ABC_3PH_EN
    S_PRE2, S_MA,
`endif
    S_M0, S_M1, S_M2, S_M3, S_M4, S_ADD
  } state_t;

  state_t       state_q, state_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic [N-1:0] a_q, a_d, b_q, b_d, cos_q, cos_d, sin_q, sin_d;
  logic [N-1:0] t_q, t_d, alpha_q, alpha_d, beta_q, beta_d;
  logic [N-1:0] p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [N-1:0] d_q, d_d, q_q, q_d;
  logic [N-1:0] mul_a, mul_b, mul_p;
`ifdef ABC_3PH_EN
  logic [N-1:0] c_q, c_d, s2_q, s2_d;
`endif

  assign mul_p = sm_mul(mul_a, mul_b);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    a_d = a_q;  b_d = b_q;  cos_d = cos_q;  sin_d = sin_q;
    t_d = t_q;  alpha_d = alpha_q;  beta_d = beta_q;
    p0_d = p0_q;  p1_d = p1_q;  p2_d = p2_q;  p3_d = p3_q;
    d_d = d_q;  q_d = q_q;
    mul_a = '0;
    mul_b = '0;
`ifdef ABC_3PH_EN
    c_d  = c_q;
    s2_d = s2_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start) begin
        a_d = bus.A;  b_d = bus.B;  cos_d = bus.CosQ;  sin_d = bus.SinQ;
`ifdef ABC_3PH_EN
        c_d = bus.C;
`endif
        state_d = S_PRE;
      end
`ifdef ABC_3PH_EN
      S_PRE: begin
        t_d     = sm_add(sm_add(a_q, a_q), sm_neg(b_q));
        s2_d    = sm_add(b_q, sm_neg(c_q));
        state_d = S_PRE2;
      end
      S_PRE2: begin
        t_d     = sm_add(t_q, sm_neg(c_q));
        state_d = S_MA;
      end
      S_MA: begin
        mul_a = t_q;  mul_b = K1;
        alpha_d = mul_p;
        state_d = S_M0;
      end
      S_M0: begin
        mul_a = s2_q;  mul_b = K3;
        beta_d  = mul_p;
        state_d = S_M1;
      end
`else
      S_PRE: begin
        t_d     = sm_add(a_q, sm_add(b_q, b_q));
        alpha_d = a_q;
        state_d = S_M0;
      end
      S_M0: begin
        mul_a = t_q;  mul_b = K3;
        beta_d  = mul_p;
        state_d = S_M1;
      end
`endif
      S_M1: begin mul_a = alpha_q; mul_b = cos_q; p0_d = mul_p; state_d = S_M2; end
      S_M2: begin mul_a = beta_q;  mul_b = sin_q; p1_d = mul_p; state_d = S_M3; end
      S_M3: begin mul_a = alpha_q; mul_b = sin_q; p2_d = mul_p; state_d = S_M4; end
      S_M4: begin mul_a = beta_q;  mul_b = cos_q; p3_d = mul_p; state_d = S_ADD; end
      S_ADD: begin
        d_d     = sm_add(p0_q, p1_q);
        q_d     = sm_add(p3_q, sm_neg(p2_q));
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;  done_q <= 1'b0;
      a_q <= '0;  b_q <= '0;  cos_q <= '0;  sin_q <= '0;
      t_q <= '0;  alpha_q <= '0;  beta_q <= '0;
      p0_q <= '0;  p1_q <= '0;  p2_q <= '0;  p3_q <= '0;
      d_q <= '0;  q_q <= '0;
`ifdef ABC_3PH_EN
      c_q <= '0;  s2_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;  done_q <= done_d;
      a_q <= a_d;  b_q <= b_d;  cos_q <= cos_d;  sin_q <= sin_d;
      t_q <= t_d;  alpha_q <= alpha_d;  beta_q <= beta_d;
      p0_q <= p0_d;  p1_q <= p1_d;  p2_q <= p2_d;  p3_q <= p3_d;
      d_q <= d_d;  q_q <= q_d;
`ifdef ABC_3PH_EN
      c_q <= c_d;  s2_q <= s2_d;
`endif
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.d    = d_q;
  assign bus.q    = q_q;
endmodule

// File: tb/tb_abc_to_dq.sv
// Scoreboard bench for abc_to_dq: driver queues expected d/q and done cycle, monitor checks on done.
`timescale 1ns/1ps
module tb_abc_to_dq;
`ifdef ABC_3PH_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 7;
`endif

  typedef struct {
    logic [23:0] d;
    logic [23:0] q;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic done_prev = 1'b0;
  exp_t sb[$];
  exp_t mon_e;

  abc_to_dq_if bus ();
  abc_to_dq dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      chk("done_single_cycle", 24'(done_prev), 24'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 with d=%h q=%h, expected no pending conversion (cycle %0d)", bus.d, bus.q, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("d", bus.d, mon_e.d);
        chk("q", bus.q, mon_e.q);
        chk("done_cycle", 24'(cyc), 24'(mon_e.cyc));
        chk("busy_at_done", 24'(bus.busy), 24'd0);
      end
    end
    done_prev = bus.done;
  end

  task automatic set_in(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c,
                        input logic [23:0] co, input logic [23:0] si);
    bus.A = a;  bus.B = b;  bus.C = c;  bus.CosQ = co;  bus.SinQ = si;
  endtask

  task automatic scramble();
    set_in(24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 24'($urandom));
  endtask

  // Called at a negedge with inputs set; returns at the negedge after the accept edge.
  task automatic issue(input logic [23:0] ed, input logic [23:0] eq);
    exp_t e;
    bus.start = 1'b1;
    e.d = ed;  e.q = eq;  e.cyc = cyc + 1 + LAT;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    chk("busy_after_accept", 24'(bus.busy), 24'd1);
  endtask

  task automatic wait_idle();
    int g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d conversions still pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [23:0] v1a, v1b, v1c, v1co, v1si, v1d, v1q;
  logic [23:0] v2a, v2b, v2c, v2co, v2si, v2d, v2q;

  initial begin
    int c0;
    exp_t e;
`ifdef ABC_3PH_EN
    v1a = 24'h001000; v1b = 24'h800800; v1c = 24'h800800; v1co = 24'h001000; v1si = 24'h0;
    v1d = 24'h000FFF; v1q = 24'h000000;
    v2a = 24'h000000; v2b = 24'h001000; v2c = 24'h801000; v2co = 24'h001000; v2si = 24'h0;
    v2d = 24'h000000; v2q = 24'h00127A;
`else
    v1a = 24'h001000; v1b = 24'h800800; v1c = 24'h0; v1co = 24'h001000; v1si = 24'h0;
    v1d = 24'h001000; v1q = 24'h000000;
    v2a = 24'h000000; v2b = 24'h001000; v2c = 24'h5A5A5A; v2co = 24'h001000; v2si = 24'h0;
    v2d = 24'h000000; v2q = 24'h00127A;
`endif
    bus.start = 1'b0;
    set_in(24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
    repeat (3) @(negedge clk);
    chk("reset_busy", 24'(bus.busy), 24'd0);
    chk("reset_done", 24'(bus.done), 24'd0);
    chk("reset_d", bus.d, 24'h0);
    chk("reset_q", bus.q, 24'h0);
    rst_n = 1'b1;
    @(negedge clk);

    set_in(v1a, v1b, v1c, v1co, v1si);
    issue(v1d, v1q);
    wait_idle();
    set_in(v2a, v2b, v2c, v2co, v2si);
    issue(v2d, v2q);
    wait_idle();
`ifndef ABC_3PH_EN
    set_in(24'h001000, 24'h800800, 24'h0, 24'h000000, 24'h001000);
    issue(24'h000000, 24'h801000);
    wait_idle();
`endif

    // A start pulse mid-conversion must be ignored.
    set_in(v1a, v1b, v1c, v1co, v1si);
    issue(v1d, v1q);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    set_in(24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Start held through done: second conversion accepted right after IDLE.
    set_in(v1a, v1b, v1c, v1co, v1si);
    bus.start = 1'b1;
    c0 = cyc;
    e.d = v1d;  e.q = v1q;  e.cyc = c0 + 1 + LAT;
    sb.push_back(e);
    e.d = v2d;  e.q = v2q;  e.cyc = c0 + 2 + 2 * LAT;
    sb.push_back(e);
    repeat (LAT + 1) @(negedge clk);
    set_in(v2a, v2b, v2c, v2co, v2si);
    @(negedge clk);
    bus.start = 1'b0;
    scramble();
    wait_idle();

    // Reset mid-conversion: outputs clear at once and no done follows.
    set_in(v1a, v1b, v1c, v1co, v1si);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 24'(bus.busy), 24'd0);
    chk("midreset_done", 24'(bus.done), 24'd0);
    chk("midreset_d", bus.d, 24'h0);
    chk("midreset_q", bus.q, 24'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    set_in(v2a, v2b, v2c, v2co, v2si);
    issue(v2d, v2q);
    wait_idle();

    chk("scoreboard_empty", 24'(sb.size()), 24'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
